// File: rtl/sram_arbiter.sv
// Two-master arbiter sharing one single-port synchronous SRAM; ties are broken round-robin.
// Define SRAM_ARB_FIXED_PRIO_EN to make master 0 win every tie instead.
module sram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_WIDTH = 8,
  parameter int WRITE_WAIT = 1,
  parameter int READ_WAIT  = 2
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WORD_WIDTH-1:0] m0_wdata,
  output logic                  m0_ready,
  output logic [WORD_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WORD_WIDTH-1:0] m1_wdata,
  output logic                  m1_ready,
  output logic [WORD_WIDTH-1:0] m1_rdata,
  output logic                  sram_clk,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_din,
  output logic                  sram_we,
  input  logic [WORD_WIDTH-1:0] sram_dout,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] WriteLast = 4'(WRITE_WAIT - 1);
  localparam logic [3:0] ReadLast  = 4'(READ_WAIT - 1);

  state_t                state_q;
  logic [3:0]            waitCnt_q;
  logic                  dir_q;
  logic                  grant_q;
  logic                  lastGrant_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] din_q;
  logic [WORD_WIDTH-1:0] m0Rdata_q;
  logic [WORD_WIDTH-1:0] m1Rdata_q;
  logic                  we_q;
  logic                  m0Ready_q;
  logic                  m1Ready_q;
  logic                  busy_q;

  logic                  anyReq;
  logic                  winner_d;
  logic                  selWrite;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic [WORD_WIDTH-1:0] selWdata;
  logic                  accessLast;

  always_comb begin
    anyReq = m0_req | m1_req;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    winner_d = ~m0_req;
`else
    // A lone requester always wins; on a tie the master not served last goes next.
    if (m0_req && m1_req) winner_d = ~lastGrant_q;
    else                  winner_d = ~m0_req;
`endif
    selWrite   = winner_d ? m1_write : m0_write;
    selAddr    = winner_d ? m1_addr  : m0_addr;
    selWdata   = winner_d ? m1_wdata : m0_wdata;
    accessLast = (waitCnt_q == (dir_q ? WriteLast : ReadLast));
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= IDLE;
      waitCnt_q   <= 4'd0;
      dir_q       <= 1'b0;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      addr_q      <= '0;
      din_q       <= '0;
      m0Rdata_q   <= '0;
      m1Rdata_q   <= '0;
      we_q        <= 1'b1;
      m0Ready_q   <= 1'b0;
      m1Ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            addr_q      <= selAddr;
            din_q       <= selWdata;
            dir_q       <= selWrite;
            grant_q     <= winner_d;
            lastGrant_q <= winner_d;
            waitCnt_q   <= 4'd0;
            we_q        <= ~selWrite;
            busy_q      <= 1'b1;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          waitCnt_q <= waitCnt_q + 4'd1;
          // Read data is taken from the SRAM on the same edge that ends the access.
          if (accessLast) begin
            we_q    <= 1'b1;
            state_q <= DONE;
            if (grant_q) begin
              m1Ready_q <= 1'b1;
              if (!dir_q) m1Rdata_q <= sram_dout;
            end else begin
              m0Ready_q <= 1'b1;
              if (!dir_q) m0Rdata_q <= sram_dout;
            end
          end
        end
        DONE: begin
          m0Ready_q <= 1'b0;
          m1Ready_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sram_clk  = hclk;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign sram_we   = we_q;
  assign m0_ready  = m0Ready_q;
  assign m1_ready  = m1Ready_q;
  assign m0_rdata  = m0Rdata_q;
  assign m1_rdata  = m1Rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_sram_arbiter;

  localparam int AW  = 4;
  localparam int WW  = 8;
  localparam int WRW = 1;
  localparam int RDW = 2;

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          m0_req = 1'b0, m0_write = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [WW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_write = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [WW-1:0] m1_wdata = '0;
  logic          m0_ready, m1_ready;
  logic [WW-1:0] m0_rdata, m1_rdata;
  logic          sram_clk, sram_we, busy;
  logic [AW-1:0] sram_addr;
  logic [WW-1:0] sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  always #5 hclk = ~hclk;

  sram_arbiter #(
    .ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WRITE_WAIT(WRW), .READ_WAIT(RDW)
  ) dut (
    .hclk(hclk), .hresetn(hresetn),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .sram_clk(sram_clk), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_we(sram_we), .sram_dout(sram_dout), .busy(busy)
  );

  function automatic logic [WW-1:0] initWord(int i);
    return WW'((i * 37 + 5) & 255);
  endfunction

  // Synchronous single-port SRAM with registered read data.
  logic [WW-1:0] sramMem [16];
  logic [WW-1:0] sramDoutQ;
  logic          memLoad = 1'b0;
  always @(posedge sram_clk) begin
    if (memLoad) begin
      for (int i = 0; i < 16; i++) sramMem[i] <= initWord(i);
    end else if (!sram_we) begin
      sramMem[sram_addr] <= sram_din;
    end
    sramDoutQ <= sramMem[sram_addr];
  end
  assign sram_dout = sramDoutQ;

  typedef struct {
    logic          m0Req, m0Write;
    logic [AW-1:0] m0Addr;
    logic [WW-1:0] m0Wdata;
    logic          m1Req, m1Write;
    logic [AW-1:0] m1Addr;
    logic [WW-1:0] m1Wdata;
    logic          expBusy, expWe;
    logic [AW-1:0] expAddr;
    logic [WW-1:0] expDin;
    logic          expM0Ready, expM1Ready;
    logic [WW-1:0] expM0Rdata, expM1Rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    m0_req = v.m0Req; m0_write = v.m0Write; m0_addr = v.m0Addr; m0_wdata = v.m0Wdata;
    m1_req = v.m1Req; m1_write = v.m1Write; m1_addr = v.m1Addr; m1_wdata = v.m1Wdata;
  endtask

  task automatic clearInputs();
    m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic doReset(input bit loadMem);
    hresetn = 1'b0;
    clearInputs();
    memLoad = loadMem;
    @(posedge hclk); #1;
    memLoad = 1'b0;
    @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  task automatic runVectors();
    for (int i = 0; i < 9; i++) begin
      @(posedge hclk); #1;
      checkOutput($sformatf("vec%0d.busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d.sram_we", i), 32'(sram_we), 32'(vecs[i].expWe));
      checkOutput($sformatf("vec%0d.sram_addr", i), 32'(sram_addr), 32'(vecs[i].expAddr));
      checkOutput($sformatf("vec%0d.sram_din", i), 32'(sram_din), 32'(vecs[i].expDin));
      checkOutput($sformatf("vec%0d.m0_ready", i), 32'(m0_ready), 32'(vecs[i].expM0Ready));
      checkOutput($sformatf("vec%0d.m1_ready", i), 32'(m1_ready), 32'(vecs[i].expM1Ready));
      checkOutput($sformatf("vec%0d.m0_rdata", i), 32'(m0_rdata), 32'(vecs[i].expM0Rdata));
      checkOutput($sformatf("vec%0d.m1_rdata", i), 32'(m1_rdata), 32'(vecs[i].expM1Rdata));
      applyStimulus(vecs[i]);
    end
  endtask

  task automatic tieTest();
    int order[$];
    int rem0 = 3;
    int rem1 = 3;
    int busyLow = 0;
    int expOrder[6];
`ifdef SRAM_ARB_FIXED_PRIO_EN
    expOrder = '{0, 0, 0, 1, 1, 1};
`else
    expOrder = '{0, 1, 0, 1, 0, 1};
`endif
    m0_req = 1'b1; m0_write = 1'b1; m0_addr = 4'h1; m0_wdata = 8'h11;
    m1_req = 1'b1; m1_write = 1'b1; m1_addr = 4'h2; m1_wdata = 8'h22;
    for (int cyc = 0; cyc < 60 && order.size() < 6; cyc++) begin
      @(posedge hclk); #1;
      checkOutput("tie.readyOverlap", 32'(m0_ready & m1_ready), 32'd0);
      if (m0_ready) begin
        order.push_back(0);
        rem0--;
        if (rem0 == 0) m0_req = 1'b0;
      end
      if (m1_ready) begin
        order.push_back(1);
        rem1--;
        if (rem1 == 0) m1_req = 1'b0;
      end
      if (!m0_ready && !m1_ready && order.size() > 0 && !busy) busyLow++;
    end
    checkOutput("tie.count", 32'(order.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) checkOutput($sformatf("tie.order%0d", i), 32'(order[i]), 32'(expOrder[i]));
    end
    checkOutput("tie.idleGaps", 32'(busyLow), 32'd5);
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic dropMidRead();
    int busyCycles;
    int r0 = 0;
    int r1 = 0;
    @(posedge hclk); #1;
    m1_req = 1'b1; m1_write = 1'b0; m1_addr = 4'h2; m1_wdata = 8'h00;
    @(posedge hclk); #1;
    checkOutput("drop.busyInAccess", 32'(busy), 32'd1);
    busyCycles = busy ? 1 : 0;
    m1_req = 1'b0; m1_write = 1'b1; m1_addr = 4'hF; m1_wdata = 8'hEE;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge hclk); #1;
      if (busy) busyCycles++;
      if (m0_ready) r0++;
      if (m1_ready) r1++;
    end
    checkOutput("drop.m1ReadyCount", 32'(r1), 32'd1);
    checkOutput("drop.m0ReadyCount", 32'(r0), 32'd0);
    checkOutput("drop.busyCycles", 32'(busyCycles), 32'(RDW + 1));
    checkOutput("drop.m1_rdata", 32'(m1_rdata), 32'h22);
    checkOutput("drop.m0_rdata", 32'(m0_rdata), 32'h00);
    clearInputs();
  endtask

  task automatic resetMidWrite();
    int first = -1;
    bit got0 = 0;
    bit got1 = 0;
    @(posedge hclk); #1;
    m0_req = 1'b1; m0_write = 1'b1; m0_addr = 4'h5; m0_wdata = 8'h77;
    @(posedge hclk); #1;
    checkOutput("rst.weBefore", 32'(sram_we), 32'd0);
    hresetn = 1'b0;
    #1;
    checkOutput("rst.weForced", 32'(sram_we), 32'd1);
    checkOutput("rst.busyCleared", 32'(busy), 32'd0);
    checkOutput("rst.addrCleared", 32'(sram_addr), 32'd0);
    clearInputs();
    for (int i = 0; i < 2; i++) begin
      @(posedge hclk); #1;
      checkOutput("rst.noReady", 32'(m0_ready | m1_ready), 32'd0);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    @(posedge hclk); #1;
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 4'h1;
    m1_req = 1'b1; m1_write = 1'b0; m1_addr = 4'h2;
    for (int cyc = 0; cyc < 20 && !(got0 && got1); cyc++) begin
      @(posedge hclk); #1;
      if (m0_ready) begin
        if (first < 0) first = 0;
        got0 = 1;
        m0_req = 1'b0;
        checkOutput("rst.m0_rdata", 32'(m0_rdata), 32'h11);
      end
      if (m1_ready) begin
        if (first < 0) first = 1;
        got1 = 1;
        m1_req = 1'b0;
        checkOutput("rst.m1_rdata", 32'(m1_rdata), 32'h22);
      end
    end
    checkOutput("rst.firstTieWinner", 32'(first), 32'd0);
    checkOutput("rst.bothServed", 32'(got0 & got1), 32'd1);
    clearInputs();
  endtask

  // Transaction-level reference: each grant at cycle g occupies cycles g+1..g+N for the
  // access, g+N+1 for the ready pulse, and the next grant is decided in cycle g+N+2.
  task automatic randomTest(input int numCycles);
    logic [WW-1:0] modelMem[16];
    logic [WW-1:0] expRd[2];
    logic [AW-1:0] expAddr = '0;
    logic [WW-1:0] expDin = '0;
    logic [WW-1:0] readVal = '0;
    bit active = 0;
    bit xWrite = 0;
    bit pend0 = 0;
    bit pend1 = 0;
    int g = 0;
    int xN = 0;
    int xWho = 0;
    int lastWin = 1;
    int winner;
    bit eBusy, eWe, eR0, eR1;
    for (int i = 0; i < 16; i++) modelMem[i] = initWord(i);
    expRd[0] = '0; expRd[1] = '0;
    for (int c = 1; c <= numCycles; c++) begin
      @(posedge hclk); #1;
      eBusy = 0; eWe = 1; eR0 = 0; eR1 = 0;
      if (active && c >= g + 1 && c <= g + xN) begin
        eBusy = 1;
        eWe = !xWrite;
      end else if (active && c == g + xN + 1) begin
        eBusy = 1;
        if (xWho == 0) eR0 = 1; else eR1 = 1;
        if (!xWrite) expRd[xWho] = readVal;
      end
      checkOutput("rnd.busy", 32'(busy), 32'(eBusy));
      checkOutput("rnd.sram_we", 32'(sram_we), 32'(eWe));
      checkOutput("rnd.m0_ready", 32'(m0_ready), 32'(eR0));
      checkOutput("rnd.m1_ready", 32'(m1_ready), 32'(eR1));
      checkOutput("rnd.sram_addr", 32'(sram_addr), 32'(expAddr));
      checkOutput("rnd.sram_din", 32'(sram_din), 32'(expDin));
      checkOutput("rnd.m0_rdata", 32'(m0_rdata), 32'(expRd[0]));
      checkOutput("rnd.m1_rdata", 32'(m1_rdata), 32'(expRd[1]));
      if (eR0) pend0 = 0;
      if (eR1) pend1 = 0;
      if (!pend0) begin
        pend0 = ($urandom_range(0, 99) < 50);
        m0_write = 1'($urandom); m0_addr = AW'($urandom); m0_wdata = WW'($urandom);
      end
      if (!pend1) begin
        pend1 = ($urandom_range(0, 99) < 50);
        m1_write = 1'($urandom); m1_addr = AW'($urandom); m1_wdata = WW'($urandom);
      end
      m0_req = pend0;
      m1_req = pend1;
      if ((!active || c >= g + xN + 2) && (pend0 || pend1)) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        winner = pend0 ? 0 : 1;
`else
        if (pend0 && pend1) winner = 1 - lastWin;
        else winner = pend0 ? 0 : 1;
`endif
        active = 1;
        g = c;
        xWho = winner;
        lastWin = winner;
        xWrite = (winner == 0) ? m0_write : m1_write;
        expAddr = (winner == 0) ? m0_addr : m1_addr;
        expDin = (winner == 0) ? m0_wdata : m1_wdata;
        xN = xWrite ? WRW : RDW;
        if (xWrite) modelMem[expAddr] = expDin;
        else readVal = modelMem[expAddr];
      end
    end
    clearInputs();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h3, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h3, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[4] = '{1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 4'h3, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h7, 8'hFF, 1'b1, 1'b1, 4'h3, 8'h00, 1'b1, 1'b0, 8'hA5, 8'h00};
    vecs[7] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h7, 8'hFF, 1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h00};
    vecs[8] = '{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 8'h00, 1'b0, 1'b0, 8'hA5, 8'h00};

    $display("[TB] directed vector table");
    doReset(1'b1);
    runVectors();

    $display("[TB] tie, drop-mid-read and reset-mid-write sequences");
    doReset(1'b0);
    tieTest();
    dropMidRead();
    resetMidWrite();

    $display("[TB] randomized traffic against reference model");
    doReset(1'b1);
    randomTest(600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
